// File: rtl/serial_neg_ctrl.sv
// serial_neg_ctrl: sequencing controller for a bit-serial two's-complement negator.
// Accepts a WIDTH-bit word, clears the serial unit, streams the word LSB-first,
// collects the returned serial bits and presents the parallel result.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake, in_data operand
//   out_valid/out_ready  result handshake, out_data result, out_ovf not-representable flag
//   ser_i, ser_r         serial data and synchronous clear driven into the negator
//   ser_y                serial result bit returned by the negator
module serial_neg_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned OUT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             ser_i,
    output logic             ser_r,
    input  logic             ser_y
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam bit          REG_OUT = (OUT_LAT != 32'd0);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] osr, osr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             ovf_nx;
    logic             in_ready_nx, out_valid_nx, ser_i_nx, ser_r_nx;
    logic             cap_en;

    assign out_data = osr;

    // With a registered unit the first SHIFT edge sees the cleared output, not bit 0.
    assign cap_en = !REG_OUT || (cnt != '0);

    // Next-state, datapath and next-output decode
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        osr_nx   = osr;
        cnt_nx   = cnt;
        ovf_nx   = out_ovf;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = SHIFT;
                    shreg_nx = in_data;
                    cnt_nx   = '0;
                    ovf_nx   = (in_data == MIN_NEG);
                end
            end
            SHIFT: begin
                shreg_nx = shreg >> 1;
                if (cap_en) begin
                    osr_nx = {ser_y, osr[WIDTH-1:1]};
                end
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = REG_OUT ? DRAIN : DONE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                osr_nx   = {ser_y, osr[WIDTH-1:1]};
                state_nx = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Outputs are registered from the next state so they change with the state itself
        in_ready_nx  = (state_nx == IDLE);
        out_valid_nx = (state_nx == DONE);
        ser_r_nx     = (state_nx == IDLE) || (state_nx == DONE);
        ser_i_nx     = (state_nx == SHIFT) && shreg_nx[0];
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            osr       <= '0;
            cnt       <= '0;
            out_ovf   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ser_r     <= 1'b1;
            ser_i     <= 1'b0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            osr       <= osr_nx;
            cnt       <= cnt_nx;
            out_ovf   <= ovf_nx;
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
            ser_r     <= ser_r_nx;
            ser_i     <= ser_i_nx;
        end
    end

endmodule
